// File: rtl/hdr_pkg.sv
// Shared definitions for the event header write and read-back paths:
// header region placement, burst length, completion error bits and word packing.
package hdr_pkg;

  localparam logic [18:0] HDR_BASE_ADDR = 19'h03F00;
  localparam int          HDR_NUM_BEATS = 32;

  localparam int ERR_SLV   = 0;
  localparam int ERR_DEC   = 1;
  localparam int ERR_SHORT = 2;
  localparam int ERR_LONG  = 3;

  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_CMPL
  } hdr_state_e;

  function automatic logic [23:0] pack_cmpl(input logic [12:0] idx, input logic [3:0] err);
    return {3'b000, idx, 4'b0000, err};
  endfunction

endpackage

// File: rtl/hdr_readout.sv
// Header read-back: one AXI4 INCR burst per event index, streamed out unbuffered
// as a single AXI4-Stream frame, followed by a {index, error} completion word.
module hdr_readout
  import hdr_pkg::*;
#(
  parameter logic [18:0] BASE_ADDR = HDR_BASE_ADDR,
  parameter int          NUM_BEATS = HDR_NUM_BEATS
) (
  input  logic        aclk,
  input  logic        aresetn,

  input  logic [15:0] s_req_tdata,
  input  logic        s_req_tvalid,
  output logic        s_req_tready,

  output logic [31:0] m_axi_araddr,
  output logic [7:0]  m_axi_arlen,
  output logic [2:0]  m_axi_arsize,
  output logic [1:0]  m_axi_arburst,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [63:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rlast,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,

  output logic [63:0] m_hdr_tdata,
  output logic        m_hdr_tvalid,
  input  logic        m_hdr_tready,
  output logic        m_hdr_tlast,

  output logic [23:0] m_cmpl_tdata,
  output logic        m_cmpl_tvalid,
  input  logic        m_cmpl_tready
);

  localparam logic [7:0] LAST_CNT = 8'(NUM_BEATS - 1);

  hdr_state_e  state_q;
  logic [12:0] idx_q;
  logic [3:0]  err_q;
  logic [7:0]  cnt_q;
  logic        ovr_q;
  logic        req_ready_q;
  logic        arvalid_q;
  logic        cmpl_valid_q;

  logic in_data;
  logic r_hs;
  logic unused_req_bits;

  assign unused_req_bits = ^s_req_tdata[15:13];

  assign in_data = (state_q == ST_DATA);
  assign r_hs    = m_axi_rvalid && m_axi_rready;

  assign s_req_tready  = req_ready_q;

  assign m_axi_araddr  = {idx_q, BASE_ADDR};
  assign m_axi_arlen   = LAST_CNT;
  assign m_axi_arsize  = 3'b011;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arvalid = arvalid_q;

  // Pass-through data path; once an over-long burst is detected the frame is
  // already closed, so remaining beats are accepted and dropped.
  assign m_axi_rready  = in_data && (m_hdr_tready || ovr_q);
  assign m_hdr_tdata   = m_axi_rdata;
  assign m_hdr_tvalid  = in_data && m_axi_rvalid && !ovr_q;
  assign m_hdr_tlast   = !ovr_q && (m_axi_rlast || (cnt_q == LAST_CNT));

  assign m_cmpl_tdata  = pack_cmpl(idx_q, err_q);
  assign m_cmpl_tvalid = cmpl_valid_q;

  // NOTE: all state below updates with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      err_q        <= '0;
      cnt_q        <= '0;
      ovr_q        <= 1'b0;
      req_ready_q  <= 1'b0;
      arvalid_q    <= 1'b0;
      cmpl_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_ready_q && s_req_tvalid) begin
            idx_q       <= s_req_tdata[12:0];
            err_q       <= '0;
            cnt_q       <= '0;
            ovr_q       <= 1'b0;
            req_ready_q <= 1'b0;
            arvalid_q   <= 1'b1;
            state_q     <= ST_ADDR;
          end else begin
            req_ready_q <= 1'b1;
          end
        end

        ST_ADDR: begin
          if (m_axi_arready) begin
            arvalid_q <= 1'b0;
            state_q   <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (r_hs) begin
            cnt_q <= cnt_q + 8'd1;
            if (m_axi_rresp == RESP_SLVERR) err_q[ERR_SLV] <= 1'b1;
            if (m_axi_rresp == RESP_DECERR) err_q[ERR_DEC] <= 1'b1;
            // Length checks only apply while the frame is still open.
            if (!ovr_q && m_axi_rlast && (cnt_q < LAST_CNT)) err_q[ERR_SHORT] <= 1'b1;
            if (!ovr_q && !m_axi_rlast && (cnt_q == LAST_CNT)) begin
              err_q[ERR_LONG] <= 1'b1;
              ovr_q           <= 1'b1;
            end
            if (m_axi_rlast) begin
              cmpl_valid_q <= 1'b1;
              state_q      <= ST_CMPL;
            end
          end
        end

        ST_CMPL: begin
          if (m_cmpl_tready) begin
            cmpl_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hdr_readout.sv
// Directed bench for hdr_readout: the bench plays AXI slave and stream sinks,
// and checks addresses, beat order, framing and completion words.
module tb_hdr_readout;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [15:0] s_req_tdata;
  logic        s_req_tvalid;
  logic        s_req_tready;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [63:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
  logic [63:0] m_hdr_tdata;
  logic        m_hdr_tvalid;
  logic        m_hdr_tready;
  logic        m_hdr_tlast;
  logic [23:0] m_cmpl_tdata;
  logic        m_cmpl_tvalid;
  logic        m_cmpl_tready;

  int total = 0;
  int bad   = 0;

  always #5 aclk = ~aclk;

  hdr_readout dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .s_req_tdata  (s_req_tdata),
    .s_req_tvalid (s_req_tvalid),
    .s_req_tready (s_req_tready),
    .m_axi_araddr (m_axi_araddr),
    .m_axi_arlen  (m_axi_arlen),
    .m_axi_arsize (m_axi_arsize),
    .m_axi_arburst(m_axi_arburst),
    .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rdata  (m_axi_rdata),
    .m_axi_rresp  (m_axi_rresp),
    .m_axi_rlast  (m_axi_rlast),
    .m_axi_rvalid (m_axi_rvalid),
    .m_axi_rready (m_axi_rready),
    .m_hdr_tdata  (m_hdr_tdata),
    .m_hdr_tvalid (m_hdr_tvalid),
    .m_hdr_tready (m_hdr_tready),
    .m_hdr_tlast  (m_hdr_tlast),
    .m_cmpl_tdata (m_cmpl_tdata),
    .m_cmpl_tvalid(m_cmpl_tvalid),
    .m_cmpl_tready(m_cmpl_tready)
  );

  function automatic logic [63:0] beat_data(input logic [12:0] idx, input int n);
    return {19'h5A5A5, idx, (32'(n) * 32'h01000193) ^ 32'hDEADBEEF};
  endfunction

  task automatic idle_inputs();
    s_req_tdata   = '0;
    s_req_tvalid  = 1'b0;
    m_axi_arready = 1'b0;
    m_axi_rdata   = '0;
    m_axi_rresp   = 2'b00;
    m_axi_rlast   = 1'b0;
    m_axi_rvalid  = 1'b0;
    m_hdr_tready  = 1'b0;
    m_cmpl_tready = 1'b0;
  endtask

  // Runs one complete request. n_sent: beats the slave returns; n_out: beats
  // expected on the header stream; abort_at >= 0 pulses reset at that beat.
  task automatic do_burst(input string name, input logic [12:0] idx, input int n_sent,
                          input int n_out, input int slv_beat, input int dec_beat,
                          input bit gaps, input logic [31:0] exp_addr,
                          input logic [23:0] exp_cmpl, input int abort_at);
    int sent;
    int out;
    int cyc;
    logic exp_tvalid;
    logic exp_rready;
    logic [63:0] exp_data;
    logic [23:0] held_cmpl;
    sent = 0;
    out  = 0;
    cyc  = 0;

    @(negedge aclk);
    s_req_tdata  = {3'b101, idx};
    s_req_tvalid = 1'b1;
    #1;
    while (!s_req_tready && cyc < 20) begin
      @(negedge aclk); #1; cyc++;
    end
    total++;
    if (!s_req_tready) begin
      bad++; $display("FAIL %s req_timeout: s_req_tready=%b required=1", name, s_req_tready);
      s_req_tvalid = 1'b0;
      return;
    end

    @(negedge aclk);
    s_req_tvalid = 1'b0;
    s_req_tdata  = '0;
    #1;
    total++;
    if (m_axi_arvalid !== 1'b1) begin
      bad++; $display("FAIL %s arvalid_latency: got=%b required=1", name, m_axi_arvalid);
    end
    total++;
    if (m_axi_araddr !== exp_addr) begin
      bad++; $display("FAIL %s araddr: got=%h required=%h", name, m_axi_araddr, exp_addr);
    end
    total++;
    if ({m_axi_arlen, m_axi_arsize, m_axi_arburst} !== {8'd31, 3'b011, 2'b01}) begin
      bad++; $display("FAIL %s ar_consts: len=%0d size=%b burst=%b required len=31 size=011 burst=01",
                      name, m_axi_arlen, m_axi_arsize, m_axi_arburst);
    end
    if (gaps) begin
      repeat (2) begin @(negedge aclk); #1; end
      total++;
      if (m_axi_arvalid !== 1'b1 || m_axi_araddr !== exp_addr) begin
        bad++; $display("FAIL %s ar_hold: arvalid=%b araddr=%h required 1/%h",
                        name, m_axi_arvalid, m_axi_araddr, exp_addr);
      end
    end
    m_axi_arready = 1'b1;
    @(negedge aclk);
    m_axi_arready = 1'b0;
    #1;
    total++;
    if (m_axi_arvalid !== 1'b0) begin
      bad++; $display("FAIL %s arvalid_drop: got=%b required=0", name, m_axi_arvalid);
    end

    cyc = 0;
    while (sent < n_sent) begin
      if (cyc >= 1000) begin
        total++; bad++;
        $display("FAIL %s r_timeout: sent=%0d required=%0d", name, sent, n_sent);
        idle_inputs();
        return;
      end
      @(negedge aclk);
      m_axi_rvalid = !gaps || ($urandom_range(0, 2) != 0) || (sent == abort_at);
      m_axi_rdata  = beat_data(idx, sent);
      m_axi_rresp  = (sent == slv_beat) ? 2'b10 : (sent == dec_beat) ? 2'b11 : 2'b00;
      m_axi_rlast  = (sent == n_sent - 1);
      m_hdr_tready = !gaps || ($urandom_range(0, 3) != 0);
      #1;
      cyc++;

      if (sent == abort_at) begin
        aresetn = 1'b0;
        #1;
        total++;
        if ({m_hdr_tvalid, m_axi_rready, m_axi_arvalid, m_cmpl_tvalid, s_req_tready} !== 5'b0) begin
          bad++; $display("FAIL %s reset_valids: tvalid=%b rready=%b arvalid=%b cmpl=%b req_rdy=%b required all 0",
                          name, m_hdr_tvalid, m_axi_rready, m_axi_arvalid, m_cmpl_tvalid, s_req_tready);
        end
        idle_inputs();
        @(negedge aclk);
        aresetn = 1'b1;
        return;
      end

      exp_tvalid = m_axi_rvalid && (out < n_out);
      exp_rready = m_hdr_tready || (out >= n_out);
      total++;
      if (m_hdr_tvalid !== exp_tvalid || m_axi_rready !== exp_rready) begin
        bad++; $display("FAIL %s beat%0d_valid_ready: tvalid=%b rready=%b required %b/%b",
                        name, sent, m_hdr_tvalid, m_axi_rready, exp_tvalid, exp_rready);
      end
      if (m_hdr_tvalid && m_hdr_tready && out < n_out) begin
        exp_data = beat_data(idx, out);
        total++;
        if (m_hdr_tdata !== exp_data || m_hdr_tlast !== (out == n_out - 1)) begin
          bad++; $display("FAIL %s out%0d: data=%h last=%b required %h/%b",
                          name, out, m_hdr_tdata, m_hdr_tlast, exp_data, (out == n_out - 1));
        end
        out++;
      end
      if (m_axi_rvalid && m_axi_rready) sent++;
    end

    @(negedge aclk);
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    m_axi_rresp  = 2'b00;
    #1;
    total++;
    if (out !== n_out) begin
      bad++; $display("FAIL %s beat_count: got=%0d required=%0d", name, out, n_out);
    end
    total++;
    if (m_cmpl_tvalid !== 1'b1 || m_cmpl_tdata !== exp_cmpl) begin
      bad++; $display("FAIL %s cmpl: valid=%b data=%h required 1/%h", name, m_cmpl_tvalid, m_cmpl_tdata, exp_cmpl);
    end
    total++;
    if (m_hdr_tvalid !== 1'b0 || m_axi_rready !== 1'b0) begin
      bad++; $display("FAIL %s data_quiet: tvalid=%b rready=%b required 0/0", name, m_hdr_tvalid, m_axi_rready);
    end
    if (gaps) begin
      held_cmpl = m_cmpl_tdata;
      repeat (2) begin @(negedge aclk); #1; end
      total++;
      if (m_cmpl_tvalid !== 1'b1 || m_cmpl_tdata !== held_cmpl || s_req_tready !== 1'b0) begin
        bad++; $display("FAIL %s cmpl_hold: valid=%b data=%h req_rdy=%b required 1/%h/0",
                        name, m_cmpl_tvalid, m_cmpl_tdata, s_req_tready, held_cmpl);
      end
    end
    m_cmpl_tready = 1'b1;
    @(negedge aclk);
    m_cmpl_tready = 1'b0;
    #1;
    total++;
    if (m_cmpl_tvalid !== 1'b0) begin
      bad++; $display("FAIL %s cmpl_drop: valid=%b required=0", name, m_cmpl_tvalid);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    aresetn = 1'b0;
    #12;
    total++;
    if ({s_req_tready, m_axi_arvalid, m_axi_rready, m_hdr_tvalid, m_cmpl_tvalid} !== 5'b0) begin
      bad++; $display("FAIL reset_outputs: req=%b ar=%b r=%b hdr=%b cmpl=%b required all 0",
                      s_req_tready, m_axi_arvalid, m_axi_rready, m_hdr_tvalid, m_cmpl_tvalid);
    end
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);
    #1;
    total++;
    if (s_req_tready !== 1'b1) begin
      bad++; $display("FAIL reset_idle_ready: s_req_tready=%b required=1", s_req_tready);
    end
  endtask

  task automatic test_basic();
    do_burst("basic", 13'h0001, 32, 32, -1, -1, 1'b0, 32'h0008_3F00, 24'h000100, -1);
  endtask

  task automatic test_backpressure();
    do_burst("backpressure", 13'h1FFF, 32, 32, -1, -1, 1'b1, 32'hFFF8_3F00, 24'h1FFF00, -1);
  endtask

  task automatic test_resp_errors();
    do_burst("resp_err", 13'h0005, 32, 32, 5, 9, 1'b0, 32'h0028_3F00, 24'h000503, -1);
  endtask

  task automatic test_short();
    do_burst("short", 13'h00A5, 21, 21, -1, -1, 1'b0, 32'h0528_3F00, 24'h00A504, -1);
  endtask

  task automatic test_long();
    do_burst("long", 13'h0100, 34, 32, -1, -1, 1'b1, 32'h0800_3F00, 24'h010008, -1);
  endtask

  task automatic test_reset_mid();
    do_burst("abort", 13'h0003, 32, 32, -1, -1, 1'b0, 32'h0018_3F00, 24'h000300, 10);
    do_burst("after_abort", 13'h0002, 32, 32, -1, -1, 1'b0, 32'h0010_3F00, 24'h000200, -1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_resp_errors();
    test_short();
    test_long();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
